// File: rtl/adder_rr_scheduler.sv
// rtl/adder_rr_scheduler.sv - round-robin scheduler sharing one adder between requesters
//
// Purpose: arbitrates NumReq valid/ready operand channels onto a single
// shared adder, one transaction in flight, and returns each sum on a tagged
// response channel with backpressure.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   req_valid/req_ready per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b         packed operands, slice i = [i*Width +: Width]
//   add_a/add_b         registered operands to the shared adder
//   add_c               adder result, sampled AddLatency cycles after accept
//   rsp_valid/rsp_ready response handshake
//   rsp_c/rsp_id        sum (wraps modulo 2^Width) and requester index
//   busy                high whenever a transaction is in flight
module adder_rr_scheduler #(
  parameter int Width      = 8,
  parameter int NumReq     = 4,
  parameter int AddLatency = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NumReq-1:0]          req_valid,
  output logic [NumReq-1:0]          req_ready,
  input  logic [NumReq*Width-1:0]    req_a,
  input  logic [NumReq*Width-1:0]    req_b,
  output logic [Width-1:0]           add_a,
  output logic [Width-1:0]           add_b,
  input  logic [Width-1:0]           add_c,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [Width-1:0]           rsp_c,
  output logic [$clog2(NumReq)-1:0]  rsp_id,
  output logic                       busy
);

  localparam int IdW  = $clog2(NumReq);
  localparam int CntW = $clog2(AddLatency + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdW-1:0]    id_q, id_d;
  logic [Width-1:0]  add_a_q, add_a_d;
  logic [Width-1:0]  add_b_q, add_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [Width-1:0]  rsp_c_q, rsp_c_d;
  logic [IdW-1:0]    rsp_id_q, rsp_id_d;

  logic              grant_found;
  logic [IdW-1:0]    grant_id;
  logic [IdW:0]      idx_ext;

  // Round-robin search. Iterating from the farthest offset down to offset 0
  // lets the requester closest to rr_ptr overwrite any farther candidate.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx_ext     = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      idx_ext = {1'b0, rr_ptr_q} + (IdW + 1)'(k);
      if (idx_ext >= (IdW + 1)'(NumReq)) begin
        idx_ext = idx_ext - (IdW + 1)'(NumReq);
      end
      if (req_valid[idx_ext[IdW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx_ext[IdW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_c_d     = rsp_c_q;
    rsp_id_d    = rsp_id_q;
    req_ready   = '0;

    unique case (state_q)
      IDLE: begin
        // Ready is suppressed during reset so no requester sees a false accept.
        if (grant_found && !rst) begin
          req_ready[grant_id] = 1'b1;
          add_a_d  = req_a[grant_id*Width +: Width];
          add_b_d  = req_b[grant_id*Width +: Width];
          id_d     = grant_id;
          rr_ptr_d = (grant_id == IdW'(NumReq - 1)) ? '0 : grant_id + 1'b1;
          cnt_d    = CntW'(AddLatency);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == CntW'(1)) begin
          rsp_c_d     = add_c;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      id_q        <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_c_q     <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_c_q     <= rsp_c_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb/tb_adder_rr_scheduler.sv - scoreboard bench for adder_rr_scheduler
module tb_adder_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic [7:0]  add_c;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_c;
  logic [1:0]  rsp_id;
  logic        busy;

  adder_rr_scheduler #(.Width(8), .NumReq(4), .AddLatency(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c     (add_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  // Shared adder: result valid one cycle after the registered operands.
  assign add_c = add_a + add_b;

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [7:0] c;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] op_q[4][$];
  logic [3:0]  last_acc;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic present(input int i);
    req_a[i*8 +: 8] = op_q[i][0][15:8];
    req_b[i*8 +: 8] = op_q[i][0][7:0];
    req_valid[i]    = 1'b1;
  endtask

  task automatic load(input int i, input logic [7:0] a, input logic [7:0] b);
    op_q[i].push_back({a, b});
    if (!req_valid[i]) present(i);
  endtask

  task automatic expect_rsp(input logic [1:0] id, input logic [7:0] c);
    exp_t e;
    e.id = id;
    e.c  = c;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    last_acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (last_acc[i]) begin
        void'(op_q[i].pop_front());
        if (op_q[i].size() > 0) present(i);
        else req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0 && !busy && req_valid == 4'b0) break;
      tick();
    end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got id=%0d c=0x%0h expected no response", rsp_id, rsp_c);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_id", rsp_id, mon_e.id);
          check("rsp_c", rsp_c, mon_e.c);
        end
      end
      if (req_valid != 4'b0) begin
        check("ready_onehot0", $onehot0(req_ready), 1);
        check("ready_subset", req_ready & ~req_valid, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_rsp_c", rsp_c, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_req_ready", req_ready, 0);
    rst = 1'b0;
    tick();

    // Single transaction with cycle-exact timing.
    load(0, 8'h12, 8'h34);
    expect_rsp(2'd0, 8'h46);
    tick();
    check("t1_accept", last_acc, 4'b0001);
    check("t1_busy", busy, 1);
    check("t1_add_a", add_a, 8'h12);
    check("t1_add_b", add_b, 8'h34);
    check("t1_no_rsp_yet", rsp_valid, 0);
    check("t1_exec_ready", req_ready, 0);
    tick();
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_c", rsp_c, 8'h46);
    check("t1_rsp_id", rsp_id, 0);
    tick();
    check("t1_pulse", rsp_valid, 0);
    check("t1_idle", busy, 0);

    // Wrap without carry.
    load(2, 8'hFF, 8'h02);
    expect_rsp(2'd2, 8'h01);
    drain("t2_drain");

    // Grant to req3 moves the pointer back to 0; then req0 beats req3.
    load(3, 8'h40, 8'h41);
    expect_rsp(2'd3, 8'h81);
    drain("t6a_drain");
    load(0, 8'h01, 8'h01);
    load(3, 8'h02, 8'h02);
    expect_rsp(2'd0, 8'h02);
    expect_rsp(2'd3, 8'h04);
    drain("t6_drain");

    // All four requesting: order 0,1,2,3,0.
    load(0, 8'h10, 8'h01);
    load(1, 8'h20, 8'h02);
    load(2, 8'h30, 8'h03);
    load(3, 8'h40, 8'h04);
    load(0, 8'h7F, 8'h01);
    expect_rsp(2'd0, 8'h11);
    expect_rsp(2'd1, 8'h22);
    expect_rsp(2'd2, 8'h33);
    expect_rsp(2'd3, 8'h44);
    expect_rsp(2'd0, 8'h80);
    drain("t3_drain");

    // Backpressure: response held stable, no new grants.
    rsp_ready = 1'b0;
    load(1, 8'h80, 8'h80);
    load(2, 8'h05, 8'h06);
    expect_rsp(2'd1, 8'h00);
    expect_rsp(2'd2, 8'h0B);
    for (int k = 0; k < 10 && !rsp_valid; k++) tick();
    check("t4_rsp_valid", rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_hold_valid", rsp_valid, 1);
      check("t4_hold_c", rsp_c, 8'h00);
      check("t4_hold_id", rsp_id, 1);
      check("t4_hold_ready", req_ready, 0);
      check("t4_hold_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    drain("t4_drain");

    // Reset during EXEC discards the transaction.
    load(3, 8'h11, 8'h22);
    tick();
    check("t5_exec", busy, 1);
    rst = 1'b1;
    tick();
    check("t5_busy", busy, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_add_a", add_a, 0);
    check("t5_add_b", add_b, 0);
    check("t5_rsp_c", rsp_c, 0);
    check("t5_rsp_id", rsp_id, 0);
    check("t5_req_ready", req_ready, 0);
    rst = 1'b0;
    repeat (3) tick();
    load(3, 8'h01, 8'h02);
    load(2, 8'h10, 8'h20);
    expect_rsp(2'd2, 8'h30);
    expect_rsp(2'd3, 8'h03);
    drain("t5_drain");
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
